// File: rtl/regfile_scoreboard_pkg.sv
// Shared widths, constants and the writeback request bundle for the register-file scoreboard.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package regfile_scoreboard_pkg;

    localparam int ADDR_W       = 5;
    localparam int DATA_W       = 32;
    localparam int NUM_REGS     = 32;
    localparam int STARVE_LIMIT = 4;
    localparam int CNT_W        = $clog2(STARVE_LIMIT + 1);

    localparam logic [ADDR_W-1:0] REG_ZERO   = '0;
    localparam logic [CNT_W-1:0]  STARVE_MAX = CNT_W'(STARVE_LIMIT);

    // One writeback request toward the register-file write port.
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] dst;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_scoreboard_wb_arbiter.sv
// Shares the single register-file write port between ALU and long-unit writebacks (ALU wins).
// Latency: winning writeback appears on rf_* one cycle after it is presented/accepted.
// Backpressure: long_wb_ready drops whenever the ALU writes; starvation counter raises throttle.
module regfile_scoreboard_wb_arbiter
    import regfile_scoreboard_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              alu_wb_valid,
    input  logic [ADDR_W-1:0] alu_wb_dst,
    input  logic [DATA_W-1:0] alu_wb_data,
    input  logic              long_wb_valid,
    input  logic [ADDR_W-1:0] long_wb_dst,
    input  logic [DATA_W-1:0] long_wb_data,
    output logic              long_wb_ready,
    output logic              throttle,
    output logic              clr_vld,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);

    wb_req_t          alu_req;
    wb_req_t          long_req;
    wb_req_t          win;
    logic             long_xfer;
    logic [CNT_W-1:0] starve_cnt;

    assign alu_req  = '{valid: alu_wb_valid,  dst: alu_wb_dst,  data: alu_wb_data};
    assign long_req = '{valid: long_wb_valid, dst: long_wb_dst, data: long_wb_data};

    // ALU writeback cannot be stalled, so the long unit only gets the port on ALU bubbles.
    assign long_wb_ready = !reset && !alu_wb_valid;
    assign long_xfer     = long_wb_valid && long_wb_ready;

    // Priority mux: pick the writeback that owns the port this cycle.
    always_comb begin
        win = '0;
        if (alu_req.valid) begin
            win = alu_req;
        end else if (long_xfer) begin
            win = long_req;
        end
    end

    // Register 0 is never written, so its writeback neither enables the port nor clears a busy bit.
    assign clr_vld  = !reset && win.valid && (win.dst != REG_ZERO);
    assign clr_addr = win.dst;
    assign throttle = (starve_cnt == STARVE_MAX);

    // Latch the winner onto the register-file write port.
    always_ff @(posedge clock) begin
        if (reset) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we    <= clr_vld;
            rf_waddr <= win.dst;
            rf_wdata <= win.data;
        end
    end

    // Count consecutive lost cycles of a pending long writeback, saturating at the limit.
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!long_wb_valid || long_xfer) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard with RAW/WAW stall and a shared register-file write port.
// Latency: busy bit set 1 cycle after issue; cleared on the edge that asserts rf_we.
// Backpressure: issue_stall holds decode; ALU writers are throttled when the long unit starves.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   issue_rs,
    input  logic [ADDR_W-1:0]   issue_rt,
    input  logic                issue_uses_rs,
    input  logic                issue_uses_rt,
    input  logic                issue_writes,
    input  logic [ADDR_W-1:0]   issue_dst,
    input  logic                issue_long,
    output logic                issue_stall,
    input  logic                alu_wb_valid,
    input  logic [ADDR_W-1:0]   alu_wb_dst,
    input  logic [DATA_W-1:0]   alu_wb_data,
    input  logic                long_wb_valid,
    input  logic [ADDR_W-1:0]   long_wb_dst,
    input  logic [DATA_W-1:0]   long_wb_data,
    output logic                long_wb_ready,
    output logic                rf_we,
    output logic [ADDR_W-1:0]   rf_waddr,
    output logic [DATA_W-1:0]   rf_wdata,
    output logic [NUM_REGS-1:0] busy_vec
);

    logic                throttle;
    logic                clr_vld;
    logic [ADDR_W-1:0]   clr_addr;
    logic                issue_fire;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;

    regfile_scoreboard_wb_arbiter u_wb_arbiter (
        .clock         (clock),
        .reset         (reset),
        .alu_wb_valid  (alu_wb_valid),
        .alu_wb_dst    (alu_wb_dst),
        .alu_wb_data   (alu_wb_data),
        .long_wb_valid (long_wb_valid),
        .long_wb_dst   (long_wb_dst),
        .long_wb_data  (long_wb_data),
        .long_wb_ready (long_wb_ready),
        .throttle      (throttle),
        .clr_vld       (clr_vld),
        .clr_addr      (clr_addr),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata)
    );

    // Hold decode on a busy source or destination, or when a new ALU writer would keep starving the long unit.
    assign issue_stall = reset ||
                         (issue_valid && ((issue_uses_rs && busy_vec[issue_rs]) ||
                                          (issue_uses_rt && busy_vec[issue_rt]) ||
                                          (issue_writes  && busy_vec[issue_dst]) ||
                                          (throttle && issue_writes && !issue_long)));

    assign issue_fire = issue_valid && !issue_stall;

    // One-hot set from issue and clear from the write port; WAW stall keeps them off the same register.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue_fire && issue_writes && (issue_dst != REG_ZERO)) begin
            set_mask[issue_dst] = 1'b1;
        end
        if (clr_vld) begin
            clr_mask[clr_addr] = 1'b1;
        end
    end

    // Busy vector: clears and sets to different registers in one edge both take effect.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy_vec <= '0;
        end else begin
            busy_vec <= (busy_vec & ~clr_mask) | set_mask;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;
    import regfile_scoreboard_pkg::*;

    logic                clock;
    logic                reset;
    logic                issue_valid;
    logic [ADDR_W-1:0]   issue_rs;
    logic [ADDR_W-1:0]   issue_rt;
    logic                issue_uses_rs;
    logic                issue_uses_rt;
    logic                issue_writes;
    logic [ADDR_W-1:0]   issue_dst;
    logic                issue_long;
    logic                issue_stall;
    logic                alu_wb_valid;
    logic [ADDR_W-1:0]   alu_wb_dst;
    logic [DATA_W-1:0]   alu_wb_data;
    logic                long_wb_valid;
    logic [ADDR_W-1:0]   long_wb_dst;
    logic [DATA_W-1:0]   long_wb_data;
    logic                long_wb_ready;
    logic                rf_we;
    logic [ADDR_W-1:0]   rf_waddr;
    logic [DATA_W-1:0]   rf_wdata;
    logic [NUM_REGS-1:0] busy_vec;

    int checks   = 0;
    int failures = 0;

    regfile_scoreboard dut (
        .clock         (clock),
        .reset         (reset),
        .issue_valid   (issue_valid),
        .issue_rs      (issue_rs),
        .issue_rt      (issue_rt),
        .issue_uses_rs (issue_uses_rs),
        .issue_uses_rt (issue_uses_rt),
        .issue_writes  (issue_writes),
        .issue_dst     (issue_dst),
        .issue_long    (issue_long),
        .issue_stall   (issue_stall),
        .alu_wb_valid  (alu_wb_valid),
        .alu_wb_dst    (alu_wb_dst),
        .alu_wb_data   (alu_wb_data),
        .long_wb_valid (long_wb_valid),
        .long_wb_dst   (long_wb_dst),
        .long_wb_data  (long_wb_data),
        .long_wb_ready (long_wb_ready),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .busy_vec      (busy_vec)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_issue(input logic v, input logic wr, input logic [ADDR_W-1:0] dst,
                             input logic lng);
        issue_valid  = v;
        issue_writes = wr;
        issue_dst    = dst;
        issue_long   = lng;
    endtask

    task automatic set_alu(input logic v, input logic [ADDR_W-1:0] dst, input logic [DATA_W-1:0] dat);
        alu_wb_valid = v;
        alu_wb_dst   = dst;
        alu_wb_data  = dat;
    endtask

    task automatic set_long(input logic v, input logic [ADDR_W-1:0] dst, input logic [DATA_W-1:0] dat);
        long_wb_valid = v;
        long_wb_dst   = dst;
        long_wb_data  = dat;
    endtask

    initial begin
        reset         = 1'b1;
        issue_rs      = '0;
        issue_rt      = '0;
        issue_uses_rs = 1'b0;
        issue_uses_rt = 1'b0;
        set_issue(1'b1, 1'b1, 5'd5, 1'b0);
        set_alu(1'b0, '0, '0);
        set_long(1'b0, '0, '0);

        // Reset held two cycles with a valid issue present
        step();
        step();
        chk("rst_stall", {31'd0, issue_stall}, 32'd1);
        chk("rst_ready", {31'd0, long_wb_ready}, 32'd0);
        chk("rst_busy", busy_vec, 32'h0);
        chk("rst_we", {31'd0, rf_we}, 32'd0);
        chk("rst_waddr", {27'd0, rf_waddr}, 32'd0);
        chk("rst_wdata", rf_wdata, 32'd0);

        // Release and issue dst=5
        reset = 1'b0;
        #1;
        chk("iss5_stall", {31'd0, issue_stall}, 32'd0);
        step();
        chk("iss5_busy", busy_vec, 32'h0000_0020);

        // RAW: reader of r5 stalls until the rf_we cycle
        set_issue(1'b1, 1'b0, 5'd0, 1'b0);
        issue_rs      = 5'd5;
        issue_uses_rs = 1'b1;
        #1;
        chk("raw_stall0", {31'd0, issue_stall}, 32'd1);
        step();
        set_alu(1'b1, 5'd5, 32'hDEAD_BEEF);
        #1;
        chk("raw_stall_wb", {31'd0, issue_stall}, 32'd1);
        step();
        set_alu(1'b0, '0, '0);
        #1;
        chk("raw_we", {31'd0, rf_we}, 32'd1);
        chk("raw_waddr", {27'd0, rf_waddr}, 32'd5);
        chk("raw_wdata", rf_wdata, 32'hDEAD_BEEF);
        chk("raw_busy", busy_vec, 32'h0);
        chk("raw_release", {31'd0, issue_stall}, 32'd0);
        step();
        issue_uses_rs = 1'b0;
        set_issue(1'b0, 1'b0, '0, 1'b0);
        #1;
        chk("raw_we_off", {31'd0, rf_we}, 32'd0);

        // WAW on r7
        set_issue(1'b1, 1'b1, 5'd7, 1'b0);
        step();
        chk("waw_busy", busy_vec, 32'h0000_0080);
        chk("waw_stall0", {31'd0, issue_stall}, 32'd1);
        set_alu(1'b1, 5'd7, 32'h0000_0077);
        #1;
        chk("waw_stall_wb", {31'd0, issue_stall}, 32'd1);
        step();
        set_alu(1'b0, '0, '0);
        #1;
        chk("waw_we", {31'd0, rf_we}, 32'd1);
        chk("waw_clear", busy_vec, 32'h0);
        chk("waw_release", {31'd0, issue_stall}, 32'd0);
        step();
        set_issue(1'b0, 1'b0, '0, 1'b0);
        set_alu(1'b1, 5'd7, 32'h0000_0078);
        #1;
        chk("waw_reissued", busy_vec, 32'h0000_0080);
        step();
        set_alu(1'b0, '0, '0);
        #1;
        chk("waw_final_clr", busy_vec, 32'h0);

        // Register 0: issue and writeback are both no-ops on state
        set_issue(1'b1, 1'b1, 5'd0, 1'b0);
        #1;
        chk("zero_stall", {31'd0, issue_stall}, 32'd0);
        step();
        set_issue(1'b0, 1'b0, '0, 1'b0);
        set_alu(1'b1, 5'd0, 32'h0000_1234);
        #1;
        chk("zero_busy", busy_vec, 32'h0);
        step();
        set_alu(1'b0, '0, '0);
        #1;
        chk("zero_we", {31'd0, rf_we}, 32'd0);

        // Set r4 and clear r2 in the same edge
        set_issue(1'b1, 1'b1, 5'd2, 1'b0);
        step();
        set_issue(1'b1, 1'b1, 5'd4, 1'b0);
        set_alu(1'b1, 5'd2, 32'h0000_0022);
        step();
        set_issue(1'b0, 1'b0, '0, 1'b0);
        set_alu(1'b0, '0, '0);
        #1;
        chk("setclr_busy", busy_vec, 32'h0000_0010);

        // Collision: ALU r3 beats long r9, long follows next cycle
        set_alu(1'b1, 5'd3, 32'h0000_0033);
        set_long(1'b1, 5'd9, 32'h0000_0099);
        #1;
        chk("col_ready0", {31'd0, long_wb_ready}, 32'd0);
        step();
        set_alu(1'b0, '0, '0);
        #1;
        chk("col_waddr_alu", {27'd0, rf_waddr}, 32'd3);
        chk("col_wdata_alu", rf_wdata, 32'h0000_0033);
        chk("col_ready1", {31'd0, long_wb_ready}, 32'd1);
        step();
        set_long(1'b0, '0, '0);
        set_alu(1'b1, 5'd4, 32'h0000_0044);
        #1;
        chk("col_we_long", {31'd0, rf_we}, 32'd1);
        chk("col_waddr_long", {27'd0, rf_waddr}, 32'd9);
        chk("col_wdata_long", rf_wdata, 32'h0000_0099);
        step();
        set_alu(1'b0, '0, '0);
        #1;
        chk("col_busy_clr", busy_vec, 32'h0);

        // Starvation: long r10 loses to ALU r11 for four cycles
        set_long(1'b1, 5'd10, 32'h0000_00AA);
        set_alu(1'b1, 5'd11, 32'h0000_00BB);
        step();
        step();
        step();
        set_issue(1'b1, 1'b1, 5'd12, 1'b0);
        #1;
        chk("starve3_no_thr", {31'd0, issue_stall}, 32'd0);
        set_issue(1'b0, 1'b0, '0, 1'b0);
        step();
        set_issue(1'b1, 1'b1, 5'd12, 1'b0);
        #1;
        chk("starve_alu_thr", {31'd0, issue_stall}, 32'd1);
        set_issue(1'b1, 1'b1, 5'd12, 1'b1);
        #1;
        chk("starve_long_ok", {31'd0, issue_stall}, 32'd0);
        set_issue(1'b1, 1'b0, 5'd12, 1'b0);
        #1;
        chk("starve_nowr_ok", {31'd0, issue_stall}, 32'd0);
        set_issue(1'b0, 1'b0, '0, 1'b0);
        step();
        set_alu(1'b0, '0, '0);
        #1;
        chk("starve_ready", {31'd0, long_wb_ready}, 32'd1);
        step();
        set_long(1'b0, '0, '0);
        set_issue(1'b1, 1'b1, 5'd12, 1'b0);
        #1;
        chk("starve_xfer_we", {31'd0, rf_we}, 32'd1);
        chk("starve_xfer_addr", {27'd0, rf_waddr}, 32'd10);
        chk("starve_cnt_clr", {31'd0, issue_stall}, 32'd0);
        set_issue(1'b0, 1'b0, '0, 1'b0);
        step();

        // Mid-operation reset with busy r2/r4/r6 and an accepted long writeback
        set_issue(1'b1, 1'b1, 5'd2, 1'b0);
        step();
        set_issue(1'b1, 1'b1, 5'd4, 1'b0);
        step();
        set_issue(1'b1, 1'b1, 5'd6, 1'b0);
        step();
        set_issue(1'b0, 1'b0, '0, 1'b0);
        set_long(1'b1, 5'd9, 32'h0000_0999);
        #1;
        chk("mid_busy", busy_vec, 32'h0000_0054);
        chk("mid_ready", {31'd0, long_wb_ready}, 32'd1);
        step();
        set_long(1'b0, '0, '0);
        reset = 1'b1;
        #1;
        chk("mid_latched", {31'd0, rf_we}, 32'd1);
        chk("mid_rst_stall", {31'd0, issue_stall}, 32'd1);
        step();
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", busy_vec, 32'h0);
        chk("mid_rst_we", {31'd0, rf_we}, 32'd0);
        step();
        chk("post_rst_we", {31'd0, rf_we}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
